lock_entry_ctrl: RTL and testbench

Sequencing controller in front of the code-lock FSM pair. Turns raw keypad `enter` presses into clean single-cycle accept events and steps a digit index through a CODE_LEN-digit attempt. Samples the per-digit correct flag from the digit checker and decides pass or fail per attempt. Adds an inter-digit timeout, a failed-attempt counter and a timed lockout after MAX_FAILS consecutive failures; drives the lock's LED-level status outputs.

---
 rtl/lock_pkg.sv | 15 +
 rtl/enter_sync_edge.sv | 15 +
 rtl/lock_entry_ctrl.sv | 135 +++++++++++++
 tb/tb_lock_entry_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, widths and helpers for the code-lock blocks
package lock_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    UNLOCKED = 3'd2,
    ERROR    = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;
  localparam int DIGIT_IDX_W = 2;
  localparam int FAIL_W = 2;
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v, input logic [FAIL_W-1:0] lim);
    return (v == lim) ? v : v + FAIL_W'(1);
  endfunction
endpackage

// File: rtl/enter_sync_edge.sv
// enter_sync_edge: 2-flop synchronizer plus a third flop giving a one-cycle rising-edge pulse
module enter_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], async_in};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  end
  assign pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/lock_entry_ctrl.sv
// lock_entry_ctrl: sequences keypad presses through a code attempt, decides pass/fail,
// and handles inter-digit timeout, failure counting and timed lockout.
module lock_entry_ctrl
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int DIGIT_TIMEOUT  = 500,
  parameter int ERR_HOLD       = 100,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       enter_raw,
  input  logic       core_correct,
  output logic [1:0] digit_idx,
  output logic       locked,
  output logic       unlocked,
  output logic       error,
  output logic       lockout,
  output logic [1:0] fail_count,
  output logic [2:0] state_dbg
);
  localparam int TW = $clog2(DIGIT_TIMEOUT + 1);
  localparam int HW = $clog2(ERR_HOLD + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DIGIT_IDX_W-1:0] LAST_IDX = DIGIT_IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAILS);
  state_e state_q, state_d;
  logic [DIGIT_IDX_W-1:0] idx_q, idx_d;
  logic [FAIL_W-1:0] fail_q, fail_d, fail_n;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [LW-1:0] lko_q, lko_d;
  logic mis_q, mis_d, fail_ev;
  logic locked_q, locked_d, unlocked_q, unlocked_d, error_q, error_d, lockout_q, lockout_d;
  logic pulse, press;
  enter_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (enter_raw),
    .pulse    (pulse)
  );
  assign press  = pulse & ena;
  assign fail_n = sat_inc(fail_q, FAIL_LIM);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    lko_d   = lko_q;
    fail_ev = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: if (press) begin
          state_d = ENTRY;
          idx_d   = DIGIT_IDX_W'(1);
          mis_d   = ~core_correct;
          tmo_d   = '0;
        end
        ENTRY: if (press) begin
          mis_d = mis_q | ~core_correct;
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + DIGIT_IDX_W'(1);
            tmo_d = '0;
          end else begin
            idx_d   = '0;
            fail_ev = mis_d;
            state_d = UNLOCKED;
            fail_d  = '0;
          end
        end else if (tmo_q == TW'(DIGIT_TIMEOUT - 1)) begin
          idx_d   = '0;
          fail_ev = 1'b1;
        end else tmo_d = tmo_q + TW'(1);
        UNLOCKED: if (press) state_d = IDLE;
        ERROR: if (hold_q == HW'(ERR_HOLD - 1)) state_d = IDLE;
          else hold_d = hold_q + HW'(1);
        LOCKOUT: if (lko_q == LW'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
          fail_d  = '0;
        end else lko_d = lko_q + LW'(1);
        default: state_d = IDLE;
      endcase
      // the final failure skips ERROR entirely and goes straight to lockout
      if (fail_ev) begin
        fail_d  = fail_n;
        state_d = (fail_n == FAIL_LIM) ? LOCKOUT : ERROR;
        hold_d  = '0;
        lko_d   = '0;
      end
    end
    locked_d   = state_d != UNLOCKED;
    unlocked_d = state_d == UNLOCKED;
    error_d    = state_d == ERROR;
    lockout_d  = state_d == LOCKOUT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mis_q      <= 1'b0;
      fail_q     <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      lko_q      <= '0;
      locked_q   <= 1'b1;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mis_q      <= mis_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      lko_q      <= lko_d;
      locked_q   <= locked_d;
      unlocked_q <= unlocked_d;
      error_q    <= error_d;
      lockout_q  <= lockout_d;
    end
  end
  assign digit_idx  = idx_q;
  assign fail_count = fail_q;
  assign state_dbg  = state_q;
  assign locked     = locked_q;
  assign unlocked   = unlocked_q;
  assign error      = error_q;
  assign lockout    = lockout_q;
endmodule

// File: tb/tb_lock_entry_ctrl.sv
// tb_lock_entry_ctrl: directed and random press sequences checked each cycle against
// a deadline-based model of the lock's attempt rules.
module tb_lock_entry_ctrl;
  localparam int CODE_LEN = 4, MAX_FAILS = 3, DIGIT_TIMEOUT = 16, ERR_HOLD = 4, LOCKOUT_CYCLES = 32;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, enter_raw = 1'b0, core_correct = 1'b1;
  logic [1:0] digit_idx, fail_count;
  logic [2:0] state_dbg;
  logic locked, unlocked, error, lockout;
  int n_chk = 0, n_err = 0;
  int m_st, m_idx, m_fail, en_t, last_t, until_t;
  bit m_mis, r1, r2, r3, prs, fail_ev;
  lock_entry_ctrl #(
    .CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS), .DIGIT_TIMEOUT(DIGIT_TIMEOUT),
    .ERR_HOLD(ERR_HOLD), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enter_raw(enter_raw), .core_correct(core_correct),
    .digit_idx(digit_idx), .locked(locked), .unlocked(unlocked), .error(error),
    .lockout(lockout), .fail_count(fail_count), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // model: states 0..4 as numbered for state_dbg, timers as deadlines in enabled cycles
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_st = 0; m_idx = 0; m_fail = 0; m_mis = 0; en_t = 0; last_t = 0; until_t = 0;
      r1 = 0; r2 = 0; r3 = 0;
    end else begin
      prs = r2 & ~r3 & ena;
      r3 = r2; r2 = r1; r1 = enter_raw;
      fail_ev = 0;
      if (ena) begin
        en_t++;
        case (m_st)
          0: if (prs) begin m_st = 1; m_idx = 1; m_mis = !core_correct; last_t = en_t; end
          1: if (prs) begin
               m_mis = m_mis | !core_correct;
               if (m_idx == CODE_LEN - 1) begin
                 m_idx = 0;
                 if (m_mis) fail_ev = 1;
                 else begin m_st = 2; m_fail = 0; end
               end else begin m_idx++; last_t = en_t; end
             end else if (en_t - last_t == DIGIT_TIMEOUT) begin m_idx = 0; fail_ev = 1; end
          2: if (prs) m_st = 0;
          3: if (en_t == until_t) m_st = 0;
          4: if (en_t == until_t) begin m_st = 0; m_fail = 0; end
          default: ;
        endcase
        if (fail_ev) begin
          if (m_fail < MAX_FAILS) m_fail++;
          m_st = (m_fail == MAX_FAILS) ? 4 : 3;
          until_t = en_t + ((m_st == 4) ? LOCKOUT_CYCLES : ERR_HOLD);
        end
      end
    end
    #1;
    check("state", state_dbg, m_st);
    check("idx", digit_idx, m_idx);
    check("fail_count", fail_count, m_fail);
    check("flags", {locked, unlocked, error, lockout}, {m_st != 2, m_st == 2, m_st == 3, m_st == 4});
  end
  task automatic press(input logic cc, input int hold, input int gap);
    enter_raw = 1'b1;
    core_correct = cc;
    repeat (hold) @(negedge clk);
    enter_raw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic attempt(input logic [3:0] cc);
    for (int i = 0; i < CODE_LEN; i++) press(cc[i], 2, 3);
    repeat (8) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    attempt(4'b1111);
    press(1, 2, 3);
    attempt(4'b1101);
    attempt(4'b0000);
    attempt(4'b1011);
    for (int i = 0; i < 3; i++) press(1, 2, 3);
    repeat (30) @(negedge clk);
    press(1, 2, 3);
    press(1, 2, 30);
    press(1, 2, 14);
    press(1, 2, 14);
    press(1, 2, 16);
    press(1, 2, 3);
    press(1, 2, 3);
    press(1, 50, 3);
    for (int i = 0; i < 3; i++) press(1, 2, 3);
    press(1, 2, 3);
    ena = 1'b0;
    enter_raw = 1'b1;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    enter_raw = 1'b0;
    repeat (4) @(negedge clk);
    attempt(4'b0111);
    attempt(4'b1110);
    press(1, 2, 3);
    press(1, 2, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_idx", digit_idx, 0);
    check("rst_fail", fail_count, 0);
    check("rst_flags", {locked, unlocked, error, lockout}, 4'b1000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 250; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      press($urandom_range(0, 9) != 0, $urandom_range(1, 6), $urandom_range(1, 20));
      ena = 1'b1;
    end
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
